// File: rtl/if_fetch_if.sv
// Instruction-memory handshake between the fetch stage and instruction memory.
// Single outstanding request; the ack may arrive in the same cycle as the request.
interface if_fetch_if;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_ack_i;
  logic [31:0] inst_rdata_i;

  modport master (
    output inst_req_o,
    output inst_addr_o,
    input  inst_ack_i,
    input  inst_rdata_i
  );

  modport slave (
    input  inst_req_o,
    input  inst_addr_o,
    output inst_ack_i,
    output inst_rdata_i
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC generation, single-outstanding memory handshake,
// 2-entry fetch queue, branch redirect with one delay slot, exception flush.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush,
  input  logic [31:0] new_pc,
  if_fetch_if.master  imem,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);

  logic [31:0] fetch_pc;
  logic [31:0] redir_pc;
  logic [31:0] drop_addr;
  logic [31:0] q_pc   [2];
  logic [31:0] q_inst [2];
  logic [1:0]  count;
  logic        req_busy;
  logic        drop;
  logic        ds_wait;

  logic        req;
  logic [31:0] req_addr;
  logic        ack;
  logic        consume;
  logic        br_take;
  logic        redirect;
  logic [31:0] redir_tgt;
  logic        latch_br;
  logic        push;
  logic        pop;

  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[0]};

  // A request is only issued when a queue slot is free for its response.
  assign req      = !rst && (req_busy || (count != 2'd2));
  // While a discarded response is still owed, keep presenting its address.
  assign req_addr = drop ? drop_addr : fetch_pc;
  assign ack      = req && imem.inst_ack_i;
  assign consume  = (count != 2'd0) && !stall[1];
  assign br_take  = branch_flag_i && !stall[2];

  always_comb begin
    redirect  = 1'b0;
    redir_tgt = fetch_pc;
    latch_br  = 1'b0;
    if (flush) begin
      redirect  = 1'b1;
      redir_tgt = new_pc;
    end else if (ds_wait && consume) begin
      redirect  = 1'b1;
      redir_tgt = redir_pc;
    end else if (br_take && consume) begin
      redirect  = 1'b1;
      redir_tgt = branch_target_i;
    end else if (br_take && !ds_wait) begin
      latch_br  = 1'b1;
    end
  end

  // Flush leaves the head in place; it is discarded along with the rest.
  assign pop  = consume && !flush;
  assign push = ack && !drop && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      count    <= 2'd0;
      req_busy <= 1'b0;
      drop     <= 1'b0;
      ds_wait  <= 1'b0;
    end else begin
      req_busy <= req && !imem.inst_ack_i;
      if (redirect) begin
        drop     <= req && !imem.inst_ack_i;
        fetch_pc <= redir_tgt;
        ds_wait  <= 1'b0;
        count    <= 2'd0;
      end else begin
        if (ack && drop) drop <= 1'b0;
        if (push) fetch_pc <= fetch_pc + 32'd4;
        if (latch_br) ds_wait <= 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // Queue data and side registers carry no reset; count gates their visibility.
  always_ff @(posedge clk) begin
    if (latch_br) redir_pc <= branch_target_i;
    if (redirect) drop_addr <= req_addr;
    if (push) begin
      if (pop) begin
        if (count == 2'd2) begin
          q_pc[0]   <= q_pc[1];
          q_inst[0] <= q_inst[1];
          q_pc[1]   <= fetch_pc;
          q_inst[1] <= imem.inst_rdata_i;
        end else begin
          q_pc[0]   <= fetch_pc;
          q_inst[0] <= imem.inst_rdata_i;
        end
      end else if (count == 2'd0) begin
        q_pc[0]   <= fetch_pc;
        q_inst[0] <= imem.inst_rdata_i;
      end else begin
        q_pc[1]   <= fetch_pc;
        q_inst[1] <= imem.inst_rdata_i;
      end
    end else if (pop) begin
      q_pc[0]   <= q_pc[1];
      q_inst[0] <= q_inst[1];
    end
  end

  assign imem.inst_req_o  = req;
  assign imem.inst_addr_o = req_addr;

  assign if_pc       = (count != 2'd0) ? q_pc[0]   : 32'h0;
  assign if_inst     = (count != 2'd0) ? q_inst[0] : 32'h0;
  assign stallreq_if = !rst && (count == 2'd0);

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: cycle table for reset/streaming/wait-state behaviour,
// hand sequences for stall, branch, flush and reset corners; consumed PCs are scoreboarded.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = 6'd0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = 32'h0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  if_fetch_if mem ();

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .flush           (flush),
    .new_pc          (new_pc),
    .imem            (mem),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .stallreq_if     (stallreq_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] minst(input logic [31:0] a);
    return a ^ 32'h3C00_A5A5;
  endfunction

  // Memory model: acks after `lat` cycles of a held request (0 = same cycle).
  int lat = 0;
  int wcnt = 0;
  assign mem.inst_ack_i   = mem.inst_req_o && (wcnt >= lat);
  assign mem.inst_rdata_i = minst(mem.inst_addr_o);
  always @(posedge clk) begin
    if (rst || !mem.inst_req_o || mem.inst_ack_i) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  logic [31:0] sb [$];
  bit mon_en = 1'b0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int          lat;
    logic        rst;
    logic [5:0]  stall;
    logic        cd;
    logic        req;
    logic [31:0] addr;
    logic        sreq;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic to_neg();
    logic [31:0] e;
    @(negedge clk);
    if (mon_en && !rst && !stallreq_if && !stall[1] && !flush) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra actual_pc=%h required=none", if_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", if_pc, e);
        chk("sb_inst", if_inst, minst(e));
      end
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    to_neg();
    to_drive();
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 6'd0; flush = 1'b0; branch_flag_i = 1'b0;
    mon_en = 1'b0;
    sb.delete();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      to_neg();
      n++;
      if (sb.size() != 0) to_drive();
    end
    mon_en = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s timeout pending=%0d required=0", nm, sb.size());
    end
    sb.delete();
    to_drive();
  endtask

  function automatic void add(input int l, input logic r, input logic [5:0] s, input logic cd,
                              input logic q, input logic [31:0] a, input logic sr,
                              input logic [31:0] p, input logic [31:0] ins);
    vec_t v;
    v = '{l, r, s, cd, q, a, sr, p, ins};
    tbl.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, zero-wait streaming, then 3-wait-state first fetch.
    add(0, 1, 6'd0, 0, 0, 32'h0,  0, 32'h0, 32'h0);
    add(0, 1, 6'd0, 1, 0, 32'h0,  0, 32'h0, 32'h0);
    add(0, 0, 6'd0, 1, 1, 32'h0,  1, 32'h0, 32'h0);
    add(0, 0, 6'd0, 1, 1, 32'h4,  0, 32'h0, minst(32'h0));
    add(0, 0, 6'd0, 1, 1, 32'h8,  0, 32'h4, minst(32'h4));
    add(0, 0, 6'd0, 1, 1, 32'hC,  0, 32'h8, minst(32'h8));
    add(0, 0, 6'd0, 1, 1, 32'h10, 0, 32'hC, minst(32'hC));
    add(3, 1, 6'd0, 0, 0, 32'h0,  0, 32'h0, 32'h0);
    add(3, 1, 6'd0, 1, 0, 32'h0,  0, 32'h0, 32'h0);
    add(3, 0, 6'd0, 1, 1, 32'h0,  1, 32'h0, 32'h0);
    add(3, 0, 6'd0, 1, 1, 32'h0,  1, 32'h0, 32'h0);
    add(3, 0, 6'd0, 1, 1, 32'h0,  1, 32'h0, 32'h0);
    add(3, 0, 6'd0, 1, 1, 32'h0,  1, 32'h0, 32'h0);
    add(3, 0, 6'd0, 1, 1, 32'h4,  0, 32'h0, minst(32'h0));

    sb = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0};
    mon_en = 1'b1;
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      lat = tbl[i].lat;
      rst = tbl[i].rst;
      stall = tbl[i].stall;
      to_neg();
      chk($sformatf("tbl%0d_req", i), 32'(mem.inst_req_o), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_stallreq", i), 32'(stallreq_if), 32'(tbl[i].sreq));
      if (tbl[i].cd) begin
        chk($sformatf("tbl%0d_addr", i), mem.inst_addr_o, tbl[i].addr);
        chk($sformatf("tbl%0d_pc", i), if_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_inst", i), if_inst, tbl[i].inst);
      end
      to_drive();
    end
    mon_en = 1'b0;
    chk("tbl_sb_drain", 32'(sb.size()), 32'h0);

    // IF/ID hold fills the queue; release must deliver in order.
    lat = 0;
    do_reset();
    sb = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    mon_en = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      stall = (i >= 4) ? 6'b000010 : 6'd0;
      to_neg();
      if (i == 6) begin
        chk("stall_full_req", 32'(mem.inst_req_o), 32'h0);
        chk("stall_head", if_pc, 32'h8);
      end
      to_drive();
    end
    stall = 6'd0;
    drain("stall_drain", 10);

    // Branch taken in the same cycle the head (delay slot) is consumed.
    lat = 0;
    do_reset();
    sb = '{32'h100, 32'h400, 32'h404};
    mon_en = 1'b1;
    flush = 1'b1; new_pc = 32'h100;
    cyc();
    flush = 1'b0;
    cyc();
    stall = 6'b000010;
    to_neg();
    chk("br_head", if_pc, 32'h100);
    to_drive();
    stall = 6'd0; branch_flag_i = 1'b1; branch_target_i = 32'h400;
    to_neg();
    chk("br_full_noreq", 32'(mem.inst_req_o), 32'h0);
    to_drive();
    branch_flag_i = 1'b0;
    to_neg();
    chk("br_tgt_addr", mem.inst_addr_o, 32'h400);
    chk("br_empty", 32'(stallreq_if), 32'h1);
    to_drive();
    drain("br_drain", 10);

    // Branch while the queue is empty and the delay-slot fetch is pending.
    lat = 2;
    do_reset();
    sb = '{32'h20, 32'h800};
    mon_en = 1'b1;
    flush = 1'b1; new_pc = 32'h20;
    cyc();
    flush = 1'b0;
    to_neg();
    chk("drop_hold_addr", mem.inst_addr_o, 32'h0);
    chk("drop_hold_req", 32'(mem.inst_req_o), 32'h1);
    to_drive();
    cyc();
    to_neg();
    chk("after_drop_addr", mem.inst_addr_o, 32'h20);
    to_drive();
    branch_flag_i = 1'b1; branch_target_i = 32'h800;
    to_neg();
    chk("ds_empty", 32'(stallreq_if), 32'h1);
    to_drive();
    branch_flag_i = 1'b0;
    cyc();
    cyc();
    to_neg();
    chk("ds_drop_addr", mem.inst_addr_o, 32'h24);
    to_drive();
    drain("ds_drain", 20);

    // Flush while a request to 0x44 is outstanding.
    lat = 2;
    do_reset();
    sb = '{32'h40, 32'h180};
    mon_en = 1'b1;
    flush = 1'b1; new_pc = 32'h40;
    cyc();
    flush = 1'b0;
    repeat (6) cyc();
    flush = 1'b1; new_pc = 32'h180;
    to_neg();
    chk("fl_pending_addr", mem.inst_addr_o, 32'h44);
    to_drive();
    flush = 1'b0;
    to_neg();
    chk("fl_drop_addr", mem.inst_addr_o, 32'h44);
    chk("fl_empty", 32'(stallreq_if), 32'h1);
    to_drive();
    to_neg();
    chk("fl_new_addr", mem.inst_addr_o, 32'h180);
    to_drive();
    drain("fl_drain", 10);

    // PC increment wraps at 2^32.
    lat = 0;
    do_reset();
    sb = '{32'hFFFF_FFFC, 32'h0, 32'h4};
    mon_en = 1'b1;
    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    cyc();
    flush = 1'b0;
    drain("wrap_drain", 10);

    // Reset asserted while a wait-state request is pending.
    lat = 3;
    do_reset();
    cyc();
    cyc();
    rst = 1'b1;
    to_neg();
    chk("rst_mid_req", 32'(mem.inst_req_o), 32'h0);
    chk("rst_mid_stallreq", 32'(stallreq_if), 32'h0);
    to_drive();
    cyc();
    rst = 1'b0;
    to_neg();
    chk("rst_after_req", 32'(mem.inst_req_o), 32'h1);
    chk("rst_after_addr", mem.inst_addr_o, 32'h0);
    chk("rst_after_stallreq", 32'(stallreq_if), 32'h1);
    to_drive();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
